constant_div_seq: RTL and testbench

//  Exact sequential divider: quotient and remainder of unsigned i_div_end by a divisor.

---
 rtl/constant_div_seq.sv | 143 ++++++++++++++
 tb/tb_constant_div_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/constant_div_seq.sv
// Exact unsigned divider: a reciprocal-multiply estimate (serial shift-add) followed by
// +1 correction steps. The divisor and reciprocal come from parameters or from input ports.
module constant_div_seq #(
    parameter int DIV_MODE  = 0,
    parameter int DIV       = 38,
    parameter int DIV_END_W = 16,
    parameter int DIV_W     = $clog2(DIV + 1),
    parameter int MUL_BPC   = 4,
    parameter int MAX_CORR  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_vld,
    output logic                 o_rdy,
    input  logic [DIV_END_W-1:0] i_div_end,
    input  logic [DIV_W-1:0]     i_div,
    input  logic [DIV_END_W:0]   i_recip,
    output logic                 o_vld,
    input  logic                 i_rdy,
    output logic [DIV_END_W-1:0] o_quo,
    output logic [DIV_W-1:0]     o_rem,
    output logic                 o_err
);
    localparam int N   = DIV_END_W;
    localparam int NP1 = N + 1;
    localparam int PW  = 2 * N + 1;
    localparam int C   = (N + MUL_BPC) / MUL_BPC;
    localparam int MCW = $clog2(C + 1);
    localparam int CW  = $clog2(MAX_CORR + 2);
    localparam logic [MCW-1:0] C_LAST   = MCW'(C - 1);
    localparam logic [CW-1:0]  CORR_MAX = CW'(MAX_CORR);
    localparam logic [N:0]     M_CONST  = NP1'((64'd1 << N) / 64'(DIV));

    typedef enum logic [2:0] {S_IDLE, S_ZERO, S_MUL, S_REM, S_CORR, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [N-1:0]       x_r, q_r, q_est;
    logic [DIV_W-1:0]   d_r, d_in;
    logic [N:0]         m_in, m_sh, r_r, r_calc, d_ext;
    logic [PW-1:0]      x_sh, prod, pp;
    logic [N+DIV_W-1:0] qd;
    logic [MCW-1:0]     mcnt;
    logic [CW-1:0]      ccnt;
    logic               accept, r_neg, r_ge, corr_step;

    assign d_in   = (DIV_MODE != 0) ? i_div : DIV_W'(DIV);
    assign m_in   = (DIV_MODE != 0) ? i_recip : M_CONST;
    assign accept = i_vld && (state == S_IDLE);
    assign o_rdy  = (state == S_IDLE);
    assign o_vld  = (state == S_DONE);

    assign q_est     = prod[2*N-1:N];
    assign qd        = {{DIV_W{1'b0}}, q_est} * {{N{1'b0}}, d_r};
    assign r_calc    = {1'b0, x_r} - qd[N:0];
    assign d_ext     = NP1'(d_r);
    assign r_neg     = r_r[N];
    assign r_ge      = !r_neg && (r_r >= d_ext);
    assign corr_step = r_ge && (ccnt < CORR_MAX);

    // MUL_BPC multiplier bits per cycle; the sum wraps at PW bits, which is exact
    // because the full product never exceeds PW bits.
    always_comb begin
        pp = '0;
        for (int b = 0; b < MUL_BPC; b++)
            if (m_sh[b]) pp = pp + (x_sh << b);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (d_in == '0) ? S_ZERO : S_MUL;
            S_ZERO: if (mcnt != '0) state_nxt = S_DONE;
            S_MUL:  if (mcnt == C_LAST) state_nxt = S_REM;
            S_REM:  state_nxt = S_CORR;
            S_CORR: if (!corr_step) state_nxt = S_DONE;
            S_DONE: if (i_rdy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_r   <= '0;
            d_r   <= '0;
            x_sh  <= '0;
            m_sh  <= '0;
            prod  <= '0;
            mcnt  <= '0;
            ccnt  <= '0;
            q_r   <= '0;
            r_r   <= '0;
            o_quo <= '0;
            o_rem <= '0;
            o_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    x_r   <= i_div_end;
                    d_r   <= d_in;
                    x_sh  <= PW'(i_div_end);
                    m_sh  <= m_in;
                    prod  <= '0;
                    mcnt  <= '0;
                    ccnt  <= '0;
                    o_err <= 1'b0;
                end
                // Zero divisor: two-cycle path to DONE carrying the error result.
                S_ZERO: begin
                    mcnt  <= mcnt + 1'b1;
                    o_quo <= '1;
                    o_rem <= '0;
                    o_err <= 1'b1;
                end
                S_MUL: begin
                    prod <= prod + pp;
                    x_sh <= x_sh << MUL_BPC;
                    m_sh <= m_sh >> MUL_BPC;
                    mcnt <= mcnt + 1'b1;
                end
                S_REM: begin
                    q_r <= q_est;
                    r_r <= r_calc;
                end
                S_CORR: if (corr_step) begin
                    q_r  <= q_r + 1'b1;
                    r_r  <= r_r - d_ext;
                    ccnt <= ccnt + 1'b1;
                end else begin
                    // Leaving with r >= D here means the correction budget ran out.
                    o_quo <= q_r;
                    o_rem <= r_r[DIV_W-1:0];
                    o_err <= r_neg || r_ge;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_constant_div_seq.sv
// Bench for constant_div_seq: a constant-divisor instance and a run-time-divisor instance,
// driven with directed cases and random cases checked against an arithmetic model.
module tb_constant_div_seq;
    logic        clk = 0, rst = 1;
    logic        req_vld = 0, dn_rdy = 1, sel = 0;
    logic [15:0] req_x = 0;
    logic [7:0]  req_d = 0;
    logic [16:0] req_m = 0;
    logic [5:0]  div0 = 0;
    logic [16:0] rcp0 = 0;
    logic        vld0, vld1, rdy0, rdy1, ov0, ov1, e0, e1;
    logic [15:0] q0, q1;
    logic [5:0]  r0;
    logic [7:0]  r1;
    logic        obs_vld, obs_rdy, obs_err;
    logic [15:0] obs_q;
    logic [7:0]  obs_r;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    assign vld0    = req_vld && !sel;
    assign vld1    = req_vld && sel;
    assign obs_vld = sel ? ov1 : ov0;
    assign obs_rdy = sel ? rdy1 : rdy0;
    assign obs_err = sel ? e1 : e0;
    assign obs_q   = sel ? q1 : q0;
    assign obs_r   = sel ? r1 : {2'b00, r0};

    constant_div_seq u0 (
        .i_clk(clk), .i_rst(rst), .i_vld(vld0), .o_rdy(rdy0), .i_div_end(req_x),
        .i_div(div0), .i_recip(rcp0), .o_vld(ov0), .i_rdy(dn_rdy),
        .o_quo(q0), .o_rem(r0), .o_err(e0));

    constant_div_seq #(.DIV_MODE(1), .DIV_W(8)) u1 (
        .i_clk(clk), .i_rst(rst), .i_vld(vld1), .o_rdy(rdy1), .i_div_end(req_x),
        .i_div(req_d), .i_recip(req_m), .o_vld(ov1), .i_rdy(dn_rdy),
        .o_quo(q1), .o_rem(r1), .o_err(e1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Arithmetic reading of the algorithm: estimate floor(x*M/2^16), then up to two
    // +1 steps while the remainder is still >= D. Latency is C+2+k with C=5.
    task automatic model(input int x, input int d, input int m,
                         output int q, output int r, output int err, output int lat);
        longint est, rr;
        int k;
        if (d == 0) begin
            q = 65535; r = 0; err = 1; lat = 2;
            return;
        end
        est = ((longint'(x) * m) >> 16) & 64'hFFFF;
        rr  = x - est * d;
        k = 0; err = 0;
        forever begin
            if (rr < 0) begin err = 1; break; end
            if (rr < d) break;
            if (k == 2) begin err = 1; break; end
            est++; rr -= d; k++;
        end
        q = int'(est); r = int'(rr); lat = 7 + k;
    endtask

    task automatic run_op(input string tag, input bit s, input int x, input int d, input int m,
                          input int eq, input int er, input int ee, input int el, input int hold);
        int n, lat, mask;
        mask = s ? 255 : 63;
        sel = s;
        dn_rdy = (hold == 0);
        @(negedge clk);
        n = 0;
        while (!obs_rdy && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_rdy"}, obs_rdy, 1);
        req_vld = 1; req_x = 16'(x); req_d = 8'(d); req_m = 17'(m);
        @(negedge clk);
        req_vld = 0;
        chk({tag, "_errclr"}, obs_err, 0);
        lat = 0;
        while (!obs_vld && lat < 60) begin @(negedge clk); lat++; end
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_quo"}, obs_q, eq);
        chk({tag, "_rem"}, obs_r, er & mask);
        chk({tag, "_err"}, obs_err, ee);
        chk({tag, "_busy"}, obs_rdy, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hvld"}, obs_vld, 1);
            chk({tag, "_hquo"}, obs_q, eq);
            chk({tag, "_hrem"}, obs_r, er & mask);
            chk({tag, "_hrdy"}, obs_rdy, 0);
        end
        dn_rdy = 1;
        @(negedge clk);
        chk({tag, "_rdy_after"}, obs_rdy, 1);
        chk({tag, "_vld_after"}, obs_vld, 0);
    endtask

    initial begin
        int x, d, m, q, r, e, l;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_vld", obs_vld, 0);
            chk("rst_rdy", obs_rdy, 1);
            chk("rst_quo", obs_q, 0);
            chk("rst_rem", obs_r, 0);
            chk("rst_err", obs_err, 0);
        end
        rst = 0;

        run_op("m0_x37",    0, 37,    0, 0, 0,    37, 0, 7, 0);
        run_op("m0_x38",    0, 38,    0, 0, 1,    0,  0, 8, 0);
        run_op("m0_xmax",   0, 65535, 0, 0, 1724, 23, 0, 8, 0);
        run_op("m0_x0",     0, 0,     0, 0, 0,    0,  0, 7, 0);
        run_op("m1_d7",     1, 100,   7, 9362,  14,    2,   0, 7, 0);
        run_op("m1_d0",     1, 5,     0, 0,     65535, 0,   1, 2, 0);
        run_op("m1_exh",    1, 1000,  7, 0,     2,     986, 1, 9, 0);
        run_op("m1_neg",    1, 100,   7, 18724, 28,    -96, 1, 7, 0);
        run_op("m0_hold",   0, 1234,  0, 0, 32, 18, 0, 7, 10);

        // Abort an operation mid-multiply, then confirm a fresh one completes.
        sel = 0;
        @(negedge clk);
        req_vld = 1; req_x = 16'd500;
        @(negedge clk);
        req_vld = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_vld", obs_vld, 0);
        chk("abort_rdy", obs_rdy, 1);
        chk("abort_quo", obs_q, 0);
        run_op("m0_fresh",  0, 777, 0, 0, 20, 17, 0, 7, 0);

        for (int i = 0; i < 12; i++) begin
            x = int'($urandom_range(0, 65535));
            model(x, 38, 65536 / 38, q, r, e, l);
            chk("rnd0_model_q", q, x / 38);
            run_op("rnd0", 0, x, 0, 0, q, r, e, l, 0);
        end
        for (int i = 0; i < 10; i++) begin
            x = int'($urandom_range(0, 65535));
            d = int'($urandom_range(1, 255));
            m = 65536 / d;
            model(x, d, m, q, r, e, l);
            chk("rnd1_model_r", r, x % d);
            run_op("rnd1", 1, x, d, m, q, r, e, l, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
